// File: rtl/div_pkg.sv
// Shared definitions for the integer divide front-end.
// Holds the operation encoding, the FSM state enum, the decode payload
// passed from div_special_decode to div_unit, and a negate helper.
package div_pkg;

    localparam int unsigned DIV_XLEN = 32;

    // RISC-V M-extension divide/remainder encodings; bit 1 selects remainder,
    // bit 0 selects unsigned.
    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } div_state_e;

    // Everything the FSM needs to capture on accept.
    typedef struct packed {
        logic                is_special;
        logic [DIV_XLEN-1:0] special_result;
        logic [DIV_XLEN-1:0] abs_a;
        logic [DIV_XLEN-1:0] abs_b;
        logic                neg_q;
        logic                neg_r;
    } div_decode_t;

    // Two's-complement negate when n is set.
    function automatic logic [DIV_XLEN-1:0] neg_if(input logic n,
                                                   input logic [DIV_XLEN-1:0] v);
        return n ? (~v + DIV_XLEN'(1)) : v;
    endfunction

endpackage

// File: rtl/div_special_decode.sv
// Combinational request decode for div_unit.
// Detects divide-by-zero and signed overflow, produces their architectural
// result, and converts signed operands to magnitudes plus sign fixups.
// Ports:
//   op   : operation (div_op_e encoding)
//   rs1  : dividend
//   rs2  : divisor
//   dec  : decode payload (special flag/result, magnitudes, sign flags)
module div_special_decode
    import div_pkg::*;
(
    input  logic [1:0]          op,
    input  logic [DIV_XLEN-1:0] rs1,
    input  logic [DIV_XLEN-1:0] rs2,
    output div_decode_t         dec
);

    localparam logic [DIV_XLEN-1:0] MIN_NEG = {1'b1, {(DIV_XLEN-1){1'b0}}};

    logic w_signed;
    logic w_is_rem;
    logic w_div_zero;
    logic w_overflow;

    always_comb begin
        w_signed   = (div_op_e'(op) == OP_DIV) || (div_op_e'(op) == OP_REM);
        w_is_rem   = op[1];
        w_div_zero = (rs2 == '0);
        w_overflow = w_signed && (rs1 == MIN_NEG) && (rs2 == '1);

        dec                = '0;
        dec.is_special     = w_div_zero || w_overflow;
        // Divide-by-zero takes priority; overflow cannot coexist with rs2 == 0.
        if (w_div_zero) begin
            dec.special_result = w_is_rem ? rs1 : '1;
        end else if (w_overflow) begin
            dec.special_result = w_is_rem ? '0 : MIN_NEG;
        end
        dec.abs_a = neg_if(w_signed && rs1[DIV_XLEN-1], rs1);
        dec.abs_b = neg_if(w_signed && rs2[DIV_XLEN-1], rs2);
        dec.neg_q = w_signed && (rs1[DIV_XLEN-1] ^ rs2[DIV_XLEN-1]);
        dec.neg_r = w_signed && rs1[DIV_XLEN-1];
    end

endmodule

// File: rtl/div_unit.sv
// RISC-V M-extension divide/remainder sequencer around an external unsigned
// base4_divider. Handles special cases locally, issues magnitudes to the
// divider, fixes up signs on return and presents a valid/ready result.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   in_valid/in_ready, op, rs1, rs2: request channel
//   flush                          : abort in-flight operation
//   out_valid/out_ready, result    : response channel
//   div_dividend/div_divisor/div_input_valid     : to base4_divider
//   div_quotient/div_remainder/div_output_valid  : from base4_divider
module div_unit
    import div_pkg::*;
#(
    parameter int unsigned XLEN = 32  // only 32 is supported
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            out_valid,
    output logic [XLEN-1:0] result,
    input  logic            out_ready,
    output logic [XLEN-1:0] div_dividend,
    output logic [XLEN-1:0] div_divisor,
    output logic            div_input_valid,
    input  logic [XLEN-1:0] div_quotient,
    input  logic [XLEN-1:0] div_remainder,
    input  logic            div_output_valid
);

    div_state_e  r_state;
    logic        r_is_rem;
    logic        r_neg_q;
    logic        r_neg_r;
    div_decode_t w_dec;
    logic        w_accept;

    div_special_decode u_decode (
        .op  (op),
        .rs1 (rs1),
        .rs2 (rs2),
        .dec (w_dec)
    );

    // Ready is combinational so reset and flush block acceptance immediately.
    assign in_ready = (r_state == S_IDLE) && !rst && !flush;
    assign w_accept = in_valid && in_ready;

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_is_rem        <= 1'b0;
            r_neg_q         <= 1'b0;
            r_neg_r         <= 1'b0;
            out_valid       <= 1'b0;
            result          <= '0;
            div_dividend    <= '0;
            div_divisor     <= '0;
            div_input_valid <= 1'b0;
        end else begin
            div_input_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_is_rem <= op[1];
                        r_neg_q  <= w_dec.neg_q;
                        r_neg_r  <= w_dec.neg_r;
                        if (w_dec.is_special) begin
                            result    <= w_dec.special_result;
                            out_valid <= 1'b1;
                            r_state   <= S_DONE;
                        end else begin
                            // Operands stay in these registers until the next accept.
                            div_dividend    <= w_dec.abs_a;
                            div_divisor     <= w_dec.abs_b;
                            div_input_valid <= 1'b1;
                            r_state         <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    r_state <= flush ? S_DRAIN : S_WAIT;
                end
                S_WAIT: begin
                    if (div_output_valid) begin
                        if (flush) begin
                            r_state <= S_IDLE;
                        end else begin
                            result <= r_is_rem ? neg_if(r_neg_r, div_remainder)
                                               : neg_if(r_neg_q, div_quotient);
                            out_valid <= 1'b1;
                            r_state   <= S_DONE;
                        end
                    end else if (flush) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DONE: begin
                    if (flush || out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    // The divider cannot be cancelled; swallow its response.
                    if (div_output_valid) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        flush;
    logic        out_valid;
    logic [31:0] result;
    logic        out_ready;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic        div_input_valid;
    logic [31:0] div_quotient;
    logic [31:0] div_remainder;
    logic        div_output_valid;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];

    // divider model state
    int          dcnt      = 0;
    int          issue_cnt = 0;
    logic [31:0] m_a       = '0;
    logic [31:0] m_b       = '0;
    logic        stray     = 1'b0;

    localparam int DLY = 4;

    div_unit #(.XLEN(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .op               (op),
        .rs1              (rs1),
        .rs2              (rs2),
        .flush            (flush),
        .out_valid        (out_valid),
        .result           (result),
        .out_ready        (out_ready),
        .div_dividend     (div_dividend),
        .div_divisor      (div_divisor),
        .div_input_valid  (div_input_valid),
        .div_quotient     (div_quotient),
        .div_remainder    (div_remainder),
        .div_output_valid (div_output_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic wait_cycle();
        @(posedge clk);
        #1;
    endtask

    // Unsigned divider model: responds DLY negedges after seeing an issue.
    always @(negedge clk) begin
        div_output_valid = 1'b0;
        if (rst) begin
            dcnt = 0;
        end else begin
            if (stray) begin
                div_output_valid = 1'b1;
                div_quotient     = 32'hA5A5_A5A5;
                div_remainder    = 32'h5A5A_5A5A;
                stray            = 1'b0;
            end else if (dcnt != 0) begin
                dcnt--;
                if (dcnt == 0) begin
                    div_output_valid = 1'b1;
                    div_quotient     = m_a / m_b;
                    div_remainder    = m_a % m_b;
                end
            end
            if (div_input_valid) begin
                m_a = div_dividend;
                m_b = div_divisor;
                dcnt = DLY;
                issue_cnt++;
            end
        end
    end

    // Monitor: compare every handshaken result against the scoreboard.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_out: got 0x%08h expected no output", result);
            end else begin
                check(name_q.pop_front(), result, exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic push, input logic [31:0] exp, input string name);
        int t = 0;
        while (!in_ready && t < 100) begin
            wait_cycle();
            t++;
        end
        check({name, "_in_ready"}, 32'(in_ready), 32'd1);
        op = o; rs1 = a; rs2 = b; in_valid = 1'b1;
        if (push) begin
            exp_q.push_back(exp);
            name_q.push_back(name);
        end
        wait_cycle();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            wait_cycle();
            t++;
        end
        check({name, "_drain"}, 32'(exp_q.size()), 32'd0);
        wait_cycle();
    endtask

    initial begin
        int snap;
        int t;
        rst = 1'b1; in_valid = 1'b0; op = 2'b00; rs1 = '0; rs2 = '0;
        flush = 1'b0; out_ready = 1'b1;
        div_quotient = '0; div_remainder = '0; div_output_valid = 1'b0;

        // reset values
        wait_cycle();
        wait_cycle();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_div_iv",    32'(div_input_valid), 32'd0);
        check("rst_result",    result, 32'd0);
        check("rst_dividend",  div_dividend, 32'd0);
        check("rst_divisor",   div_divisor, 32'd0);
        check("rst_in_ready",  32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // signed divide/remainder with negative dividend
        send(2'b00, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, "div_m7_2");
        wait_drain("div_m7_2");
        check("div_m7_2_dividend", m_a, 32'd7);
        check("div_m7_2_divisor",  m_b, 32'd2);
        send(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, "rem_m7_2");
        wait_drain("rem_m7_2");

        // divide by zero
        snap = issue_cnt;
        send(2'b01, 32'h1234_5678, 32'd0, 1'b1, 32'hFFFF_FFFF, "divu_by0");
        check("divu_by0_latency", 32'(out_valid), 32'd1);
        check("divu_by0_no_issue_now", 32'(div_input_valid), 32'd0);
        wait_drain("divu_by0");
        send(2'b11, 32'd5, 32'd0, 1'b1, 32'd5, "remu_by0");
        wait_drain("remu_by0");
        check("by0_no_issue", 32'(issue_cnt), 32'(snap));

        // signed overflow
        snap = issue_cnt;
        send(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, "div_ovf");
        check("div_ovf_latency", 32'(out_valid), 32'd1);
        wait_drain("div_ovf");
        send(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, "rem_ovf");
        wait_drain("rem_ovf");
        check("ovf_no_issue", 32'(issue_cnt), 32'(snap));

        // backpressure on the result
        out_ready = 1'b0;
        send(2'b01, 32'd100, 32'd7, 1'b1, 32'd14, "divu_100_7");
        t = 0;
        while (!out_valid && t < 50) begin
            wait_cycle();
            t++;
        end
        check("divu_100_7_seen", 32'(out_valid), 32'd1);
        check("divu_100_7_latency", 32'(div_output_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            wait_cycle();
            check("hold_result", result, 32'd14);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        wait_drain("divu_100_7");
        check("after_hs_in_ready", 32'(in_ready), 32'd1);

        // flush during WAIT -> DRAIN
        send(2'b01, 32'd100, 32'd7, 1'b0, 32'd0, "flush_op");
        wait_cycle();
        flush = 1'b1;
        #1;
        check("flush_blocks_ready", 32'(in_ready), 32'd0);
        wait_cycle();
        flush = 1'b0;
        t = 0;
        while (!div_output_valid && t < 50) begin
            check("drain_in_ready", 32'(in_ready), 32'd0);
            check("drain_out_valid", 32'(out_valid), 32'd0);
            wait_cycle();
            t++;
        end
        check("drain_resp_seen", 32'(div_output_valid), 32'd1);
        check("drain_exit_in_ready", 32'(in_ready), 32'd1);
        check("drain_exit_out_valid", 32'(out_valid), 32'd0);
        send(2'b11, 32'd100, 32'd7, 1'b1, 32'd2, "remu_100_7");
        wait_drain("remu_100_7");

        // flush in DONE discards the result
        out_ready = 1'b0;
        send(2'b01, 32'd9, 32'd0, 1'b0, 32'd0, "flush_done_op");
        check("flush_done_pre", 32'(out_valid), 32'd1);
        flush = 1'b1;
        wait_cycle();
        flush = 1'b0;
        #1;
        check("flush_done_out_valid", 32'(out_valid), 32'd0);
        check("flush_done_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;

        // flush wins over in_valid in IDLE
        snap = issue_cnt;
        op = 2'b01; rs1 = 32'd10; rs2 = 32'd3;
        flush = 1'b1; in_valid = 1'b1;
        #1;
        check("flush_vs_valid_ready", 32'(in_ready), 32'd0);
        wait_cycle();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_vs_valid_no_iv", 32'(div_input_valid), 32'd0);
        wait_cycle();
        wait_cycle();
        check("flush_vs_valid_no_out", 32'(out_valid), 32'd0);
        check("flush_vs_valid_no_issue", 32'(issue_cnt), 32'(snap));

        // stray divider response in IDLE is ignored
        stray = 1'b1;
        wait_cycle();
        wait_cycle();
        wait_cycle();
        check("stray_out_valid", 32'(out_valid), 32'd0);
        check("stray_in_ready", 32'(in_ready), 32'd1);

        // reset during WAIT
        send(2'b01, 32'd100, 32'd7, 1'b0, 32'd0, "rst_op");
        wait_cycle();
        rst = 1'b1;
        wait_cycle();
        check("rstw_out_valid", 32'(out_valid), 32'd0);
        check("rstw_div_iv",    32'(div_input_valid), 32'd0);
        check("rstw_result",    result, 32'd0);
        check("rstw_dividend",  div_dividend, 32'd0);
        check("rstw_divisor",   div_divisor, 32'd0);
        check("rstw_in_ready",  32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("rstw_release_ready", 32'(in_ready), 32'd1);
        send(2'b00, 32'd20, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFFA, "div_20_m3");
        wait_drain("div_20_m3");
        wait_cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
